instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Consumer side of the program counter (PC) interface.
- Takes `addr` from PC and fetches the instruction word over a req/ack instruction-memory port.
- Buffers fetched words for decode in a small FIFO.
- Drives the PC enable `E`.
- Observes the PC jump strobe `J` and discards any stale in-flight or buffered fetches when it fires.

Parameters:
- AW, 16, address width (matches PC `addr`).
- DW, 16, instruction width.
- DEPTH, 2, instruction FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  AW  current PC value.
- J  in  1  jump strobe, same one PC uses to load B.
- E  out  1  PC advance enable, one-cycle pulse per accepted fetch.
- mem_req  out  1  instruction memory request.
- mem_addr  out  AW  request address, registered.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DW  instruction word, valid with mem_ack.
- instr  out  DW  head-of-FIFO instruction.
- instr_pc  out  AW  address of head instruction.
- instr_valid  out  1  FIFO non-empty and J low.
- instr_ready  in  1  decode accepts head.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, FIFO empty, pointers=0, count=0.
  - mem_req=0, mem_addr=0, E=0, instr_valid=0.
- Definitions:
  - space = (count + (state≠IDLE)) < DEPTH.
  - pop = instr_valid & instr_ready.
- State IDLE:
  - If J=1: flush FIFO, no request, stay IDLE.
  - Else if space: mem_req←1, mem_addr←addr, go WAIT.
- State WAIT:
  - mem_req and mem_addr held stable until mem_ack; a request is never retracted.
  - mem_ack=1 & J=0: push {mem_addr, mem_rdata}, E=1 (combinational, this cycle only), mem_req←0, go IDLE.
  - mem_ack=1 & J=1: data dropped, E=0, FIFO flushed, go IDLE.
  - mem_ack=0 & J=1: FIFO flushed, go DROP.
- State DROP:
  - mem_req held.
  - On mem_ack: data dropped, E=0, mem_req←0, go IDLE.
  - J in DROP flushes FIFO again (idempotent).
- E only ever asserts in WAIT with mem_ack=1 & J=0.
  - PC therefore updates at the same edge as the push.
  - IDLE issues the next address on the following cycle.
  - Peak throughput is 1 instruction per 2 cycles with zero-wait memory (ack the cycle after req).
- FIFO:
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push never occurs when full, guaranteed by space including the outstanding fetch.
  - Pop when empty impossible (instr_valid=0).
- Flush:
  - J has priority over push and pop.
  - Pointers and count go to 0 at the edge.
  - instr_valid is forced 0 in the J cycle, so no handshake completes then.
- Reset mid-WAIT/DROP:
  - Returns to IDLE; mem_req drops immediately.
  - The memory must tolerate an abandoned request (system reset only).

Decomposition:
- Shared defines file (rv16_defs.vh):
  - AW/DW defaults.
  - State encodings IFS_IDLE=2'd0, IFS_WAIT=2'd1, IFS_DROP=2'd2.
- One sub-module: instr_fetch_fifo (DEPTH×(AW+DW), push/pop/flush, count out).
- FSM and handshake logic stay in instr_fetch.

Test Plan:
- Reset then zero-wait memory (ack 1 cycle after req), addr sequence 0x0000,0x0001… with instr_ready=1:
  - instr_pc sequence 0x0000,0x0001,0x0002.
  - E pulses every 2nd cycle.
  - mem_rdata matches instr in order.
- instr_ready=0, memory acks with 3-cycle latency:
  - After 2 fetches (0x0000,0x0001), count=2.
  - mem_req stays 0 and E stays 0 indefinitely.
  - Raising instr_ready resumes fetch at 0x0002.
- J=1 while WAIT on 0x0005 (ack arrives 2 cycles later) with 1 entry buffered:
  - FIFO empties, instr_valid=0.
  - State DROP; the ack produces no push and E=0.
  - Next request issues with the new addr 0x0040.
- J coincident with mem_ack:
  - No push, E=0, FIFO empty next cycle, state IDLE.
- Simultaneous push and pop at count=1:
  - count stays 1; correct instr/instr_pc ordering across pointer wrap (≥6 entries total).
- rst asserted low mid-WAIT:
  - mem_req, E, instr_valid go 0 asynchronously (before next clk edge).
  - After release, first request uses current addr.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// +--------------------------------------------------------------------+
// | instr_fetch_pkg : shared widths and fetch FSM state encoding        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package instr_fetch_pkg;
  localparam int c_aw    = 16;
  localparam int c_dw    = 16;
  localparam int c_depth = 2;

  typedef enum logic [1:0] {
    IFS_IDLE = 2'd0,
    IFS_WAIT = 2'd1,
    IFS_DROP = 2'd2
  } ifs_state_t;
endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// +--------------------------------------------------------------------+
// | instr_fetch_if : PC, instruction-memory and decode signals          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int AW = c_aw,
  parameter int DW = c_dw
);
  logic [AW-1:0] addr;
  logic          J;
  logic          E;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;

  modport master (
    input  addr, J, mem_ack, mem_rdata, instr_ready,
    output E, mem_req, mem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output addr, J, mem_ack, mem_rdata, instr_ready,
    input  E, mem_req, mem_addr, instr, instr_pc, instr_valid
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
// +--------------------------------------------------------------------+
// | instr_fetch_fifo : small FIFO of {pc, instr} with flush priority    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire logic                       i_flush,
  input  wire logic [WIDTH-1:0]           i_din,
  output logic      [WIDTH-1:0]           o_dout,
  output logic      [$clog2(DEPTH):0]     o_count
);
  localparam int c_pw = $clog2(DEPTH);

  logic [c_pw-1:0]  r_wptr;
  logic [c_pw-1:0]  r_rptr;
  logic [c_pw:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +--------------------------------------------------------------------+
// | instr_fetch : PC-driven instruction fetch with req/ack memory port  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int AW    = c_aw,
  parameter int DW    = c_dw,
  parameter int DEPTH = c_depth
) (
  input  wire logic      clk,
  input  wire logic      rst,
  instr_fetch_if.master  bus
);
  localparam int c_cw = $clog2(DEPTH) + 1;

  ifs_state_t       r_state;
  ifs_state_t       w_state_nxt;
  logic             r_mem_req;
  logic             w_mem_req_nxt;
  logic [AW-1:0]    r_mem_addr;
  logic [AW-1:0]    w_mem_addr_nxt;
  logic             w_push;
  logic             w_e;
  logic             w_pop;
  logic             w_valid;
  logic             w_space;
  logic [c_cw-1:0]  w_count;
  logic [c_cw:0]    w_occ;
  logic [AW+DW-1:0] w_head;

  // An outstanding fetch already owns a FIFO slot
  assign w_occ   = {1'b0, w_count} + {{c_cw{1'b0}}, (r_state != IFS_IDLE)};
  assign w_space = w_occ < (c_cw+1)'(DEPTH);
  assign w_valid = (w_count != '0) && !bus.J;
  assign w_pop   = w_valid && bus.instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IFS_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_push         = 1'b0;
    w_e            = 1'b0;
    case (r_state)
      IFS_IDLE: begin
        if (!bus.J && w_space) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = bus.addr;
          w_state_nxt    = IFS_WAIT;
        end
      end
      IFS_WAIT: begin
        if (bus.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IFS_IDLE;
          if (!bus.J) begin
            w_push = 1'b1;
            w_e    = 1'b1;
          end
        end else if (bus.J) begin
          w_state_nxt = IFS_DROP;
        end
      end
      IFS_DROP: begin
        // Request stays up until the stale response arrives, then is discarded
        if (bus.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IFS_IDLE;
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = IFS_IDLE;
      end
    endcase
  end

  instr_fetch_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.J),
    .i_din   ({r_mem_addr, bus.mem_rdata}),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign bus.E           = w_e;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr       = w_head[DW-1:0];
  assign bus.instr_pc    = w_head[AW+DW-1:DW];
  assign bus.instr_valid = w_valid;
endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +--------------------------------------------------------------------+
// | tb_instr_fetch : directed bench with queue-based fetch model        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int c_aw    = 16;
  localparam int c_dw    = 16;
  localparam int c_depth = 2;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.AW(c_aw), .DW(c_dw)) bus ();

  instr_fetch #(.AW(c_aw), .DW(c_dw), .DEPTH(c_depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Environment controls
  int          lat    = 0;
  bit          roa    = 1'b0;
  bit          pc_load = 1'b0;
  logic [15:0] pc_tgt = '0;
  logic [15:0] jtgt   = '0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a ^ 16'hC3A5) + 16'h0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tmo(input string name);
    n_total++;
    $display("FAIL %s: got timeout, expected event at %0t", name, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic jump(input logic [15:0] t);
    @(posedge clk); #2;
    jtgt  = t;
    bus.J = 1'b1;
    @(posedge clk); #1;
    bus.J = 1'b0;
  endtask

  // PC and instruction memory
  initial begin
    bit          e_s, j_s;
    logic [15:0] jt_s;
    int          wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      e_s = bus.E; j_s = bus.J; jt_s = jtgt;
      @(posedge clk); #1;
      if (pc_load) begin bus.addr = pc_tgt; pc_load = 1'b0; end
      else if (j_s) bus.addr = jt_s;
      else if (e_s) bus.addr = bus.addr + 16'd1;
      bus.mem_ack = 1'b0;
      if (rst && bus.mem_req) begin
        if (wcnt >= lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = memf(bus.mem_addr);
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
      if (roa) bus.instr_ready = bus.mem_ack;
    end
  end

  // Behavioural model: outstanding fetch + queue of buffered entries
  ent_t        q[$];
  bit          m_out, m_stale;
  logic [15:0] m_oaddr, m_maddr;
  bit          exp_e, exp_v;
  int          occ;

  initial begin
    m_out = 0; m_stale = 0; m_oaddr = '0; m_maddr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_E", bus.E, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        q.delete();
        m_out = 0; m_stale = 0; m_maddr = '0;
      end else begin
        exp_e = m_out && !m_stale && bus.mem_ack && !bus.J;
        exp_v = (q.size() > 0) && !bus.J;
        chk("mem_req", bus.mem_req, m_out);
        chk("mem_addr", bus.mem_addr, m_maddr);
        chk("E", bus.E, exp_e);
        chk("instr_valid", bus.instr_valid, exp_v);
        if (exp_v) begin
          chk("instr", bus.instr, q[0].d);
          chk("instr_pc", bus.instr_pc, q[0].pc);
        end
        occ = q.size();
        if (bus.J) q.delete();
        else begin
          if (exp_v && bus.instr_ready) void'(q.pop_front());
          if (exp_e) q.push_back('{pc: m_oaddr, d: bus.mem_rdata});
        end
        if (m_out) begin
          if (bus.mem_ack) begin m_out = 0; m_stale = 0; end
          else if (bus.J) m_stale = 1;
        end else if (!bus.J && occ < c_depth) begin
          m_out = 1; m_stale = 0; m_oaddr = bus.addr; m_maddr = bus.addr;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ecyc[$];
    logic [15:0] ppc[$];
    logic [15:0] pdat[$];
    logic [15:0] t1_pc[3];
    logic [15:0] t1_d[3];
    bit          found;

    bus.addr = '0; bus.J = 1'b0; bus.mem_ack = 1'b0;
    bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset_req_lit", bus.mem_req, 0);
    chk("reset_valid_lit", bus.instr_valid, 0);
    cyc(2);
    bus.instr_ready = 1'b1;
    lat = 0;
    rst = 1'b1;

    // Zero-wait streaming
    t1_pc = '{16'h0000, 16'h0001, 16'h0002};
    t1_d  = '{16'hC4A6, 16'hC4A5, 16'hC4A8};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bus.E) ecyc.push_back(i);
      if (bus.instr_valid && bus.instr_ready) begin
        ppc.push_back(bus.instr_pc);
        pdat.push_back(bus.instr);
      end
    end
    chk("t1_e_count", ecyc.size(), 4);
    if (ecyc.size() > 0) chk("t1_first_e", ecyc[0], 1);
    for (int k = 1; k < ecyc.size(); k++) chk("t1_e_gap", ecyc[k] - ecyc[k-1], 2);
    if (ppc.size() < 3) tmo("t1_pops");
    else for (int k = 0; k < 3; k++) begin
      chk("t1_pc", ppc[k], t1_pc[k]);
      chk("t1_data", pdat[k], t1_d[k]);
    end

    // Back-pressure with slow memory
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    lat = 2;
    jump(16'h0000);
    cyc(20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_req_idle", bus.mem_req, 0);
      chk("t2_E_idle", bus.E, 0);
      chk("t2_full_valid", bus.instr_valid, 1);
    end
    chk("t2_head_pc", bus.instr_pc, 16'h0000);
    @(posedge clk); #1;
    bus.instr_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (bus.mem_req) found = 1;
    end
    if (found) chk("t2_resume_addr", bus.mem_addr, 16'h0002); else tmo("t2_resume");

    // Jump while waiting on 0x0005 with one entry buffered
    bus.instr_ready = 1'b0;
    lat = 2;
    jump(16'h0004);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk); #2;
      if (bus.mem_req && bus.mem_addr == 16'h0005) found = 1;
    end
    if (!found) tmo("t3_wait5");
    else begin
      chk("t3_buffered", bus.instr_valid, 1);
      jtgt = 16'h0040; bus.J = 1'b1;
      #1 chk("t3_valid_in_J", bus.instr_valid, 0);
      @(posedge clk); #1;
      bus.J = 1'b0;
      #1 chk("t3_valid_after", bus.instr_valid, 0);
      found = 0;
      for (int k = 0; k < 6 && !found; k++) begin
        @(negedge clk);
        if (bus.mem_ack) begin found = 1; chk("t3_E_on_stale_ack", bus.E, 0); end
      end
      if (!found) tmo("t3_stale_ack");
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
        @(posedge clk); #2;
        if (bus.mem_req) found = 1;
      end
      if (found) chk("t3_new_addr", bus.mem_addr, 16'h0040); else tmo("t3_new_req");
    end

    // Jump coincident with ack
    lat = 1;
    jump(16'h0010);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.E) found = 1;
    end
    if (!found) tmo("t4_first_fetch");
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #2;
      if (bus.mem_req && bus.mem_ack) begin
        found = 1;
        jtgt = 16'h0020; bus.J = 1'b1;
        #1 chk("t4_E_with_J", bus.E, 0);
      end
    end
    if (!found) tmo("t4_ack");
    @(posedge clk); #1;
    bus.J = 1'b0;
    #1;
    chk("t4_empty", bus.instr_valid, 0);
    chk("t4_idle_req", bus.mem_req, 0);

    // Push and pop together at count 1 across pointer wrap
    lat = 0;
    jump(16'h000E);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.E) found = 1;
    end
    if (!found) tmo("t5_first_fetch");
    @(posedge clk); #1;
    roa = 1'b1;
    ppc.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t5_valid_kept", bus.instr_valid, 1);
      if (bus.instr_valid && bus.instr_ready) ppc.push_back(bus.instr_pc);
    end
    @(posedge clk); #1;
    roa = 1'b0;
    bus.instr_ready = 1'b0;
    chk("t5_pops_ge6", ppc.size() >= 6, 1);
    for (int k = 0; k < ppc.size(); k++) chk("t5_order", ppc[k], 16'h000E + 16'(k));

    // Asynchronous reset mid-fetch
    lat = 3;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #2;
      if (bus.mem_req && bus.instr_valid) found = 1;
    end
    if (!found) tmo("t6_wait");
    #1 rst = 1'b0;
    #1;
    chk("t6_req_async", bus.mem_req, 0);
    chk("t6_E_async", bus.E, 0);
    chk("t6_valid_async", bus.instr_valid, 0);
    pc_tgt = 16'h0123; pc_load = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #2;
      if (bus.mem_req) found = 1;
    end
    if (found) chk("t6_first_addr", bus.mem_addr, 16'h0123); else tmo("t6_req");

    cyc(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
